// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared types and constants for the NTT stage scheduler: FSM encoding,
// mode encodings and default sizing of a 1024-point, 8-BFU transform.
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } ntt_state_e;

    localparam int CONF_W = 3;
    localparam int P_W    = 4;
    localparam int K_W    = 6;

    localparam logic [CONF_W-1:0] CONF_NTT_A = 3'b001;
    localparam logic [CONF_W-1:0] CONF_NTT_B = 3'b100;

    localparam int DEF_NUM_STAGES       = 10;
    localparam int DEF_CYCLES_PER_STAGE = 64;
    localparam int DEF_GAP_CYCLES       = 4;

    // Any encoding other than the two NTT codes means INTT.
    function automatic logic is_ntt(input logic [CONF_W-1:0] c);
        return (c == CONF_NTT_A) || (c == CONF_NTT_B);
    endfunction

endpackage

// File: rtl/ntt_stage_scheduler_if.sv
// Control/issue bundle between top-level control, the scheduler and the
// twiddle address generator / BFU array.
interface ntt_sched_if;
    import ntt_ctrl_pkg::*;

    // start: single-cycle request, only honoured while the scheduler is idle.
    // issue_valid qualifies p/k/conf in the same cycle (no back-pressure;
    // stall is the only throttle); tf_valid is issue_valid one cycle later.
    logic              start;
    logic [CONF_W-1:0] conf_in;
    logic              stall;
    logic [CONF_W-1:0] conf;
    logic [P_W-1:0]    p;
    logic [K_W-1:0]    k;
    logic              issue_valid;
    logic              tf_valid;
    logic              stage_done;
    logic              busy;
    logic              done;

    modport master (
        output start, conf_in, stall,
        input  conf, p, k, issue_valid, tf_valid, stage_done, busy, done
    );

    modport slave (
        input  start, conf_in, stall,
        output conf, p, k, issue_valid, tf_valid, stage_done, busy, done
    );

endinterface

// File: rtl/ntt_stage_scheduler_k_map.sv
// Stage/cycle to twiddle index mapper: stage p >= 3 holds each twiddle for
// 2^(p-3) cycles, the last three stages use a fresh twiddle every cycle.
module ntt_k_map
    import ntt_ctrl_pkg::*;
(
    input  logic [P_W-1:0] p_i,
    input  logic [K_W-1:0] cyc_i,
    output logic [K_W-1:0] k_o
);

    logic [P_W-1:0] sh;

    assign sh  = p_i - 4'd3;
    assign k_o = (p_i >= 4'd3) ? (cyc_i >> sh) : cyc_i;

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Butterfly issue sequencer: walks p from NUM_STAGES-1 down to 0, issuing
// CYCLES_PER_STAGE butterflies per stage with a drain gap between stages.
module ntt_stage_scheduler
    import ntt_ctrl_pkg::*;
#(
    parameter int NUM_STAGES       = DEF_NUM_STAGES,
    parameter int CYCLES_PER_STAGE = DEF_CYCLES_PER_STAGE,
    parameter int GAP_CYCLES       = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    ntt_sched_if.slave  sif,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_GAP  = ST_GAP;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [P_W-1:0] P_FIRST  = P_W'(NUM_STAGES - 1);
    localparam logic [K_W-1:0] CYC_LAST = K_W'(CYCLES_PER_STAGE - 1);
    localparam logic [7:0]     GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [K_W-1:0]    cyc_q, cyc_d;
    logic [7:0]        gap_q, gap_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              iv_q, iv_d;
    logic              tf_q;
    logic              sd_q, sd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_issue;

    // k is computed from the next-state pointer so it is registered with p.
    ntt_k_map u_k_map (
        .p_i   (p_d),
        .cyc_i (cyc_d),
        .k_o   (k_d)
    );

    // cyc_q/p_q name the butterfly shown this cycle; iv_q says whether it
    // actually issued, so a stalled slot is retried without advancing cyc.
    assign last_issue = iv_q && (cyc_q == CYC_LAST);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cyc_d   = cyc_q;
        gap_d   = gap_q;
        conf_d  = conf_q;
        iv_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    state_d = S_RUN;
                    conf_d  = sif.conf_in;
                    p_d     = P_FIRST;
                    cyc_d   = '0;
                    iv_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    if (p_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    if (iv_q) cyc_d = cyc_q + 6'd1;
                    iv_d = !sif.stall;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    p_d     = p_q - 4'd1;
                    cyc_d   = '0;
                    iv_d    = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        sd_d = iv_d && (cyc_d == CYC_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            cyc_q   <= '0;
            gap_q   <= '0;
            conf_q  <= '0;
            k_q     <= '0;
            iv_q    <= 1'b0;
            tf_q    <= 1'b0;
            sd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cyc_q   <= cyc_d;
            gap_q   <= gap_d;
            conf_q  <= conf_d;
            k_q     <= k_d;
            iv_q    <= iv_d;
            tf_q    <= iv_q;
            sd_q    <= sd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sif.conf        = conf_q;
    assign sif.p           = p_q;
    assign sif.k           = k_q;
    assign sif.issue_valid = iv_q;
    assign sif.tf_valid    = tf_q;
    assign sif.stage_done  = sd_q;
    assign sif.busy        = busy_q;
    assign sif.done        = done_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: cycle-exact trace model of whole runs
// (with stalls, ignored starts, mid-run reset) for GAP_CYCLES of 4 and 1.
module tb_ntt_stage_scheduler;
  import ntt_ctrl_pkg::*;

  localparam int NS  = 10;
  localparam int CPS = 64;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start;
  logic       stall;
  logic [2:0] conf_in;
  logic       sel;
  logic [1:0] dbg0, dbg1;

  ntt_sched_if sif0();
  ntt_sched_if sif1();

  assign sif0.start   = start;
  assign sif0.stall   = stall;
  assign sif0.conf_in = conf_in;
  assign sif1.start   = start;
  assign sif1.stall   = stall;
  assign sif1.conf_in = conf_in;

  ntt_stage_scheduler #(.NUM_STAGES(NS), .CYCLES_PER_STAGE(CPS), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .sif(sif0), .dbg_state_o(dbg0));
  ntt_stage_scheduler #(.NUM_STAGES(NS), .CYCLES_PER_STAGE(CPS), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sif(sif1), .dbg_state_o(dbg1));

  logic [3:0] km_p;
  logic [5:0] km_cyc, km_k;
  ntt_k_map u_km (.p_i(km_p), .cyc_i(km_cyc), .k_o(km_k));

  logic [2:0] o_conf;
  logic [3:0] o_p;
  logic [5:0] o_k;
  logic       o_iv, o_tf, o_sd, o_busy, o_done;
  assign o_conf = sel ? sif1.conf        : sif0.conf;
  assign o_p    = sel ? sif1.p           : sif0.p;
  assign o_k    = sel ? sif1.k           : sif0.k;
  assign o_iv   = sel ? sif1.issue_valid : sif0.issue_valid;
  assign o_tf   = sel ? sif1.tf_valid    : sif0.tf_valid;
  assign o_sd   = sel ? sif1.stage_done  : sif0.stage_done;
  assign o_busy = sel ? sif1.busy        : sif0.busy;
  assign o_done = sel ? sif1.done        : sif0.done;

  // scoreboard: one record per cycle {stall,done,busy,iv,sd,p[3:0],k[5:0]}
  int checks = 0;
  int failures = 0;
  logic [14:0] exp_q[$];
  int stall_tab[NS][CPS];

  function automatic int kref(input int p, input int c);
    return (p >= 3) ? c / (1 << (p - 3)) : c;
  endfunction

  function automatic logic [14:0] rec(input bit st, input bit dn, input bit bz,
                                      input bit iv, input bit sd, input int p, input int k);
    return {st, dn, bz, iv, sd, 4'(p), 6'(k)};
  endfunction

  function automatic int stall_sum();
    int s = 0;
    for (int a = 0; a < NS; a++)
      for (int b = 0; b < CPS; b++) s += stall_tab[a][b];
    return s;
  endfunction

  task automatic clear_stalls();
    for (int a = 0; a < NS; a++)
      for (int b = 0; b < CPS; b++) stall_tab[a][b] = 0;
  endtask

  task automatic build_exp(input int gap);
    exp_q.delete();
    for (int s = NS - 1; s >= 0; s--) begin
      for (int c = 0; c < CPS; c++) begin
        for (int n = 0; n < stall_tab[s][c]; n++) exp_q.push_back(rec(1, 0, 1, 0, 0, s, kref(s, c)));
        exp_q.push_back(rec(0, 0, 1, 1, c == CPS - 1, s, kref(s, c)));
      end
      if (s > 0)
        for (int g = 0; g < gap; g++) exp_q.push_back(rec(0, 0, 1, 0, 0, 0, 0));
    end
    exp_q.push_back(rec(0, 1, 0, 0, 0, 0, 0));
  endtask

  // driver + per-cycle compare of one complete run
  task automatic run_check(input string name, input logic [2:0] mode, input int gap,
                           input bit noise, input int abort_idx, input bit start_in_done,
                           output bit aborted);
    int n_busy, n_iv, n_tf, total, exp_busy;
    logic prev_iv;
    logic [14:0] e;
    logic [4:0] got, want;
    n_busy = 0; n_iv = 0; n_tf = 0; prev_iv = 1'b0; aborted = 1'b0;
    build_exp(gap);
    total = exp_q.size();
    exp_busy = NS * CPS + (NS - 1) * gap + stall_sum();
    for (int i = 0; i < total; i++) begin
      e = exp_q[i];
      @(negedge clk);
      if (i == 0) begin
        start = 1'b1; conf_in = mode; stall = 1'b0;
      end else begin
        start   = noise && ($urandom_range(0, 15) == 0);
        conf_in = 3'($urandom);
        if (e[14]) stall = 1'b1;
        else if (!e[11]) stall = 1'($urandom);
        else stall = 1'b0;
      end
      @(posedge clk); #1;
      got  = {o_done, o_busy, o_iv, o_sd, o_tf};
      want = {e[13], e[12], e[11], e[10], prev_iv};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s ctrl idx=%0d done/busy/iv/sd/tf got=%b exp=%b", name, i, got, want);
      end
      if (e[11] || e[14]) begin
        checks++;
        if ({o_p, o_k} !== e[9:0]) begin
          failures++;
          $display("FAIL %s pk idx=%0d got p=%0d k=%0d exp p=%0d k=%0d", name, i, o_p, o_k, e[9:6], e[5:0]);
        end
      end
      if (e[12]) begin
        checks++;
        if (o_conf !== mode) begin
          failures++;
          $display("FAIL %s conf idx=%0d got=%b exp=%b", name, i, o_conf, mode);
        end
      end
      n_busy += int'(o_busy); n_iv += int'(o_iv); n_tf += int'(o_tf);
      prev_iv = e[11];
      if (i == abort_idx) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      // start pulse during the done cycle must be ignored
      @(negedge clk);
      start = start_in_done; conf_in = 3'($urandom); stall = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0; stall = 1'b0;
      checks++;
      if ({o_busy, o_iv, o_done, o_conf} !== {3'b000, mode}) begin
        failures++;
        $display("FAIL %s after_done busy/iv/done/conf got=%b exp=%b", name, {o_busy, o_iv, o_done, o_conf}, {3'b000, mode});
      end
      checks++;
      if (n_busy != exp_busy) begin
        failures++;
        $display("FAIL %s busy_count got=%0d exp=%0d", name, n_busy, exp_busy);
      end
      checks++;
      if (n_iv != NS * CPS || n_tf != NS * CPS) begin
        failures++;
        $display("FAIL %s valid_count got iv=%0d tf=%0d exp=%0d", name, n_iv, n_tf, NS * CPS);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bit ab;
    rst = 1'b0; start = 1'b0; stall = 1'b0; conf_in = 3'b000; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sif0.conf, sif0.p, sif0.k, sif0.issue_valid, sif0.tf_valid, sif0.stage_done, sif0.busy, sif0.done} !== 19'd0) begin
      failures++;
      $display("FAIL reset dut0 outputs got=%h exp=0", {sif0.conf, sif0.p, sif0.k, sif0.issue_valid, sif0.tf_valid, sif0.stage_done, sif0.busy, sif0.done});
    end
    checks++;
    if ({sif1.conf, sif1.p, sif1.k, sif1.issue_valid, sif1.tf_valid, sif1.stage_done, sif1.busy, sif1.done} !== 19'd0) begin
      failures++;
      $display("FAIL reset dut1 outputs got=%h exp=0", {sif1.conf, sif1.p, sif1.k, sif1.issue_valid, sif1.tf_valid, sif1.stage_done, sif1.busy, sif1.done});
    end
    @(negedge clk);
    rst = 1'b1;
    ab = 1'b0;
  endtask

  task automatic test_kmap();
    for (int p = 0; p < NS; p++) begin
      for (int c = 0; c < CPS; c++) begin
        km_p = 4'(p);
        km_cyc = 6'(($urandom_range(0, 1) == 0) ? c : $urandom_range(0, 63));
        #1;
        checks++;
        if (km_k !== 6'(kref(p, int'(km_cyc)))) begin
          failures++;
          $display("FAIL kmap p=%0d cyc=%0d got=%0d exp=%0d", p, km_cyc, km_k, kref(p, int'(km_cyc)));
        end
      end
    end
  endtask

  task automatic test_ntt_basic();
    bit ab;
    clear_stalls();
    run_check("ntt_basic", 3'b001, 4, 1'b0, -1, 1'b0, ab);
  endtask

  task automatic test_intt();
    bit ab;
    clear_stalls();
    run_check("intt", 3'b010, 4, 1'b1, -1, 1'b0, ab);
  endtask

  task automatic test_back_to_back();
    bit ab;
    clear_stalls();
    run_check("b2b_first", 3'($urandom_range(0, 7)), 4, 1'b1, -1, 1'b1, ab);
    run_check("b2b_second", 3'b100, 4, 1'b1, -1, 1'b0, ab);
  endtask

  task automatic test_stall();
    bit ab;
    clear_stalls();
    stall_tab[7][63] = 5;
    run_check("stall_p7_c63", 3'b001, 4, 1'b0, -1, 1'b0, ab);
  endtask

  task automatic test_random_stall();
    bit ab;
    clear_stalls();
    for (int n = 0; n < 4; n++)
      stall_tab[$urandom_range(0, NS - 1)][$urandom_range(1, CPS - 1)] = $urandom_range(1, 6);
    run_check("random_stall", 3'($urandom_range(0, 7)), 4, 1'b1, -1, 1'b0, ab);
  endtask

  task automatic test_midrun_reset();
    bit ab;
    clear_stalls();
    run_check("pre_reset", 3'b001, 4, 1'b0, 5 * CPS + 5 * 4 + 20, 1'b0, ab);
    checks++;
    if (!ab) begin
      failures++;
      $display("FAIL midrun_abort reached got=0 exp=1");
    end
    start = 1'b0; stall = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_conf, o_p, o_k, o_iv, o_tf, o_sd, o_busy, o_done} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset outputs got=%h exp=0", {o_conf, o_p, o_k, o_iv, o_tf, o_sd, o_busy, o_done});
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({o_done, o_busy, o_iv} !== 3'b000) begin
        failures++;
        $display("FAIL in_reset done/busy/iv got=%b exp=000", {o_done, o_busy, o_iv});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_check("post_reset", 3'b011, 4, 1'b0, -1, 1'b0, ab);
  endtask

  task automatic test_gap1();
    bit ab;
    clear_stalls();
    do_reset();
    sel = 1'b1;
    run_check("gap1", 3'b100, 1, 1'b0, -1, 1'b0, ab);
    sel = 1'b0;
  endtask

  initial begin
    start = 1'b0; stall = 1'b0; conf_in = 3'b000; sel = 1'b0;
    km_p = 4'd0; km_cyc = 6'd0;
    test_reset();
    test_kmap();
    test_ntt_basic();
    test_intt();
    test_back_to_back();
    test_stall();
    test_random_stall();
    test_midrun_reset();
    test_gap1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
